// File: rtl/pc_pkg.sv
// pc_pkg: shared next-PC select encodings and select-width helper
package pc_pkg;
  localparam int PC_SRC_SEQ = 0;
  localparam int PC_SRC_RET = 1;
  localparam int PC_SRC_TGT_BASE = 2;
  function automatic int sel_w(input int num_targets);
    return $clog2(num_targets + PC_SRC_TGT_BASE);
  endfunction
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack with top pointer, count and error events
module pc_ras #(
  parameter int WIDTH = 16,
  parameter int RAS_DEPTH = 8,
  localparam int CW = $clog2(RAS_DEPTH + 1),
  localparam int PW = $clog2(RAS_DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow_evt,
  output logic             underflow_evt
);
  logic [WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0] r_tp;
  logic [CW-1:0] r_cnt;
  logic w_pop;
  logic w_swap;
  assign empty = r_cnt == '0;
  assign full = r_cnt == CW'(RAS_DEPTH);
  assign count = r_cnt;
  assign top = empty ? '0 : r_mem[r_tp];
  assign w_pop = pop & ~empty;
  // push+pop together replaces the top slot in place, so depth never changes
  assign w_swap = push & w_pop;
  assign overflow_evt = push & ~w_pop & full;
  assign underflow_evt = pop & empty;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tp <= '0;
      r_cnt <= '0;
    end else if (push && !w_swap) begin
      r_tp <= r_tp + PW'(1);
      r_cnt <= full ? r_cnt : r_cnt + CW'(1);
    end else if (w_pop && !w_swap) begin
      r_tp <= r_tp - PW'(1);
      r_cnt <= r_cnt - CW'(1);
    end
  end
  always_ff @(posedge clock) begin
    if (push) r_mem[w_swap ? r_tp : r_tp + PW'(1)] <= push_data;
  end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with next-PC select, return-address stack and sticky stack errors
module pc_unit import pc_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int STEP = 2,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int NUM_TARGETS = 6,
  parameter int RAS_DEPTH = 8,
  localparam int SEL_W = sel_w(NUM_TARGETS),
  localparam int CW = $clog2(RAS_DEPTH + 1)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         pc_write,
  input  logic [SEL_W-1:0]             pc_src,
  input  logic [NUM_TARGETS*WIDTH-1:0] target_bus,
  input  logic                         call,
  input  logic                         clear_flags,
  output logic [WIDTH-1:0]             pc_cur,
  output logic [WIDTH-1:0]             ras_top,
  output logic [CW-1:0]                ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);
  logic [WIDTH-1:0] r_pc;
  logic r_ovf;
  logic r_unf;
  logic [WIDTH-1:0] w_seq;
  logic [WIDTH-1:0] w_tgt;
  logic [WIDTH-1:0] w_next;
  logic w_hit;
  logic w_ret;
  logic w_ovf_evt;
  logic w_unf_evt;
  assign w_seq = r_pc + WIDTH'(STEP);
  assign w_ret = pc_src == SEL_W'(PC_SRC_RET);
  always_comb begin
    w_tgt = '0;
    w_hit = 1'b0;
    for (int k = 0; k < NUM_TARGETS; k++)
      if (pc_src == SEL_W'(PC_SRC_TGT_BASE + k)) begin
        w_tgt = target_bus[k*WIDTH +: WIDTH];
        w_hit = 1'b1;
      end
  end
  // a return on an empty stack holds the PC; unused select codes fall back to sequential
  assign w_next = w_ret ? (ras_empty ? r_pc : ras_top) : w_hit ? w_tgt : w_seq;
  pc_ras #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clock(clock),
    .reset_n(reset_n),
    .push(pc_write & call),
    .pop(pc_write & w_ret),
    .push_data(w_seq),
    .top(ras_top),
    .count(ras_count),
    .empty(ras_empty),
    .full(ras_full),
    .overflow_evt(w_ovf_evt),
    .underflow_evt(w_unf_evt)
  );
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= RESET_VECTOR;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (pc_write) r_pc <= w_next;
      r_ovf <= w_ovf_evt | (r_ovf & ~clear_flags);
      r_unf <= w_unf_evt | (r_unf & ~clear_flags);
    end
  end
  assign pc_cur = r_pc;
  assign ras_overflow = r_ovf;
  assign ras_underflow = r_unf;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: table-driven and sequence checks of pc_unit through an expected-result queue
module tb_pc_unit;
  typedef struct {
    logic wr;
    logic [2:0] src;
    logic call;
    logic clr;
    logic [15:0] tgt;
    logic [15:0] pc;
    logic [15:0] top;
    logic [3:0] cnt;
    logic ovf;
    logic unf;
  } vec_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic pc_write = 1'b0;
  logic [2:0] pc_src = '0;
  logic [63:0] target_bus = '0;
  logic call = 1'b0;
  logic clear_flags = 1'b0;
  logic [15:0] pc_cur;
  logic [15:0] ras_top;
  logic [3:0] ras_count;
  logic ras_empty;
  logic ras_full;
  logic ras_overflow;
  logic ras_underflow;
  int n_chk = 0;
  int n_fail = 0;
  vec_t exp_q[$];
  vec_t tbl[$];
  pc_unit #(.WIDTH(16), .STEP(2), .RESET_VECTOR(16'h0100), .NUM_TARGETS(4), .RAS_DEPTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .pc_write(pc_write), .pc_src(pc_src),
    .target_bus(target_bus), .call(call), .clear_flags(clear_flags),
    .pc_cur(pc_cur), .ras_top(ras_top), .ras_count(ras_count), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  function automatic vec_t mk(logic wr, logic [2:0] src, logic cl, logic clr, logic [15:0] tgt,
                              logic [15:0] pc, logic [15:0] top, logic [3:0] cnt, logic ovf, logic unf);
    vec_t v;
    v.wr = wr; v.src = src; v.call = cl; v.clr = clr; v.tgt = tgt;
    v.pc = pc; v.top = top; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask
  task automatic check_state(input string nm, input vec_t e);
    chk({nm, " pc"}, pc_cur, e.pc);
    chk({nm, " top"}, ras_top, e.top);
    chk({nm, " count"}, 16'(ras_count), 16'(e.cnt));
    chk({nm, " empty"}, 16'(ras_empty), 16'(e.cnt == 0));
    chk({nm, " full"}, 16'(ras_full), 16'(e.cnt == 8));
    chk({nm, " overflow"}, 16'(ras_overflow), 16'(e.ovf));
    chk({nm, " underflow"}, 16'(ras_underflow), 16'(e.unf));
  endtask
  task automatic apply(input string nm, input vec_t v);
    vec_t e;
    pc_write = v.wr;
    pc_src = v.src;
    call = v.call;
    clear_flags = v.clr;
    for (int k = 0; k < 4; k++) target_bus[k*16 +: 16] = 16'hA000 + 16'(k * 16'h111);
    if (v.src >= 2 && v.src < 6) target_bus[(int'(v.src) - 2)*16 +: 16] = v.tgt;
    exp_q.push_back(v);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check_state(nm, e);
  endtask
  initial begin
    #12;
    check_state("reset", mk(0, 0, 0, 0, 0, 16'h0100, 0, 0, 0, 0));
    @(negedge clock);
    reset_n = 1'b1;
    tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0102, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0104, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0106, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0108, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0108, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 16'h0108, 0, 0, 0, 0));
    tbl.push_back(mk(0, 2, 1, 0, 16'h0999, 16'h0108, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 0, 16'h0200, 16'h0200, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 1, 0, 16'h0400, 16'h0400, 16'h0202, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 16'h0202, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 0, 0, 16'h0300, 16'h0300, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 16'h0300, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0, 16'h0300, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 16'h0300, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 16'h0302, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4, 0, 0, 16'h004E, 16'h004E, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 1, 0, 16'h0700, 16'h0700, 16'h0050, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 16'h0050, 16'h0702, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 16'h0702, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 0, 0, 16'hFFFE, 16'hFFFE, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
    tbl.push_back(mk(1, 7, 0, 0, 0, 16'h0002, 0, 0, 0, 0));
    tbl.push_back(mk(1, 6, 0, 0, 0, 16'h0004, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 16'h0004, 16'h0006, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 1, 0, 16'h0006, 0, 0, 0, 0));
    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);
    apply("jump10", mk(1, 2, 0, 0, 16'h0010, 16'h0010, 0, 0, 0, 0));
    for (int i = 1; i <= 9; i++)
      apply($sformatf("call%0d", i), mk(1, 2, 1, 0, 16'(16 * (i + 1)), 16'(16 * (i + 1)),
            16'(16 * i + 2), 4'(i > 8 ? 8 : i), 1'(i == 9), 0));
    for (int j = 1; j <= 8; j++)
      apply($sformatf("ret%0d", j), mk(1, 1, 0, 0, 0, 16'(16 * (10 - j) + 2),
            j < 8 ? 16'(16 * (9 - j) + 2) : 16'h0, 4'(8 - j), 1, 0));
    apply("ret_empty", mk(1, 1, 0, 0, 0, 16'h0022, 0, 0, 1, 1));
    for (int k = 1; k <= 3; k++)
      apply($sformatf("refill%0d", k), mk(1, 0, 1, 0, 0, 16'(16'h22 + 2 * k),
            16'(16'h22 + 2 * k), 4'(k), 1, 1));
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_state("async_reset", mk(0, 0, 0, 0, 0, 16'h0100, 0, 0, 0, 0));
    pc_write = 1'b1;
    call = 1'b1;
    @(negedge clock);
    check_state("reset_held", mk(0, 0, 0, 0, 0, 16'h0100, 0, 0, 0, 0));
    reset_n = 1'b1;
    apply("post_reset", mk(1, 0, 0, 0, 0, 16'h0102, 0, 0, 0, 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
